// File: rtl/rom_prefetch_buffer.sv
// Instruction prefetch buffer between the CU fetch path and the QSPI ROM controller.
// Keeps up to DEPTH consecutive ROM words ahead of the CU pc, refilling one read at a time.
module rom_prefetch_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned STEP  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        fetch_req,
    input  logic [22:0] fetch_addr,
    output logic        fetch_valid,
    output logic [31:0] fetch_data,
    output logic        qspi_start,
    output logic [23:0] qspi_addr,
    input  logic [31:0] qspi_data,
    input  logic        qspi_busy,
    output logic [15:0] miss_count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [22:0] Step = 23'(STEP);
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     fifo_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [22:0]     head_addr_q, head_addr_d;
    logic [22:0]     next_addr_q, next_addr_d;
    logic            stale_q, stale_d;
    logic [15:0]     miss_count_q, miss_count_d;
    logic [23:0]     qspi_addr_q, qspi_addr_d;

    logic pending;
    logic pop;
    logic miss;
    logic kill;
    logic write;

    assign fetch_valid = fetch_req && (count_q != '0) && (fetch_addr == head_addr_q) && !flush;
    assign fetch_data  = fifo_q[rd_ptr_q];

    // An empty buffer whose head is the requested pc is already being filled for it,
    // so re-requesting that pc must not restart the fill.
    assign pending = (count_q == '0) && (fetch_addr == head_addr_q);
    assign pop     = fetch_valid;
    assign miss    = fetch_req && !fetch_valid && !flush && !pending;
    assign kill    = miss || flush;

    assign qspi_start = (state_q == StIssue);
    assign qspi_addr  = qspi_addr_q;
    assign miss_count = miss_count_q;

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        head_addr_d  = head_addr_q;
        next_addr_d  = next_addr_q;
        stale_d      = stale_q;
        miss_count_d = miss_count_q;
        qspi_addr_d  = qspi_addr_q;
        write        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!kill && (count_q < Full)) begin
                    state_d     = StIssue;
                    qspi_addr_d = {1'b1, next_addr_q};
                    next_addr_d = next_addr_q + Step;
                end
            end
            StIssue: begin
                if (qspi_busy) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!qspi_busy) begin
                    state_d = StIdle;
                    stale_d = 1'b0;
                    write   = !stale_q && !kill;
                end
            end
            default: state_d = StIdle;
        endcase

        if (write) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end

        if (kill) begin
            count_d     = '0;
            rd_ptr_d    = wr_ptr_q;
            head_addr_d = fetch_addr;
            next_addr_d = fetch_addr;
            // Only a read that stays outstanding past this edge needs its data dropped.
            if ((state_q != StIdle) && (state_d != StIdle)) begin
                stale_d = 1'b1;
            end
        end else begin
            count_d = count_q + CntW'(write) - CntW'(pop);
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + PtrW'(1);
                head_addr_d = head_addr_q + Step;
            end
        end

        if (miss && (miss_count_q != 16'hFFFF)) begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            head_addr_q  <= '0;
            next_addr_q  <= '0;
            stale_q      <= 1'b0;
            miss_count_q <= '0;
            qspi_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            head_addr_q  <= head_addr_d;
            next_addr_q  <= next_addr_d;
            stale_q      <= stale_d;
            miss_count_q <= miss_count_d;
            qspi_addr_q  <= qspi_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_q <= '{default: '0};
        end else if (write) begin
            fifo_q[wr_ptr_q] <= qspi_data;
        end
    end

endmodule

// File: tb/tb_rom_prefetch_buffer.sv
// Directed self-checking bench for rom_prefetch_buffer with a behavioural QSPI responder
// that stays busy for 10 cycles and returns 0xA000_0000 | address.
module tb_rom_prefetch_buffer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        fetch_req;
    logic [22:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        qspi_start;
    logic [23:0] qspi_addr;
    logic [31:0] qspi_data;
    logic        qspi_busy;
    logic [15:0] miss_count;

    int errors = 0;
    int checks = 0;

    logic [23:0] rd_log [$];
    logic [23:0] cur_addr;
    int          busy_cnt;

    rom_prefetch_buffer #(
        .DEPTH(4),
        .STEP (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .qspi_start (qspi_start),
        .qspi_addr  (qspi_addr),
        .qspi_data  (qspi_data),
        .qspi_busy  (qspi_busy),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // QSPI responder, updated on the falling edge so the DUT sees stable inputs.
    initial begin
        qspi_busy = 1'b0;
        qspi_data = '0;
        busy_cnt  = 0;
        cur_addr  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                qspi_busy = ~qspi_busy;
                busy_cnt  = 0;
            end else if (busy_cnt != 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    qspi_busy = 1'b0;
                    qspi_data = 32'hA000_0000 | {9'b0, cur_addr[22:0]};
                end
            end else if (qspi_busy) begin
                qspi_busy = 1'b0;
            end else if (qspi_start) begin
                qspi_busy = 1'b1;
                busy_cnt  = 10;
                cur_addr  = qspi_addr;
                rd_log.push_back(qspi_addr);
            end
        end
    end

    // Entered at posedge+1; returns at posedge+2 of the cycle fetch_valid is high.
    task automatic wait_valid(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            #1;
            if (fetch_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_log(input string tag, input int target, input int budget);
        int c;
        c = 0;
        while ((rd_log.size() < target) && (c < budget)) begin
            @(posedge clk);
            #1;
            c++;
        end
        check(tag, 32'(rd_log.size() >= target), 32'd1);
    endtask

    task automatic wait_busy(input string tag, input int budget);
        int c;
        c = 0;
        while (!qspi_busy && (c < budget)) begin
            @(posedge clk);
            #1;
            c++;
        end
        check(tag, 32'(qspi_busy), 32'd1);
    endtask

    task automatic pop_now(input string tag, input logic [22:0] addr);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        #1;
        check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
        check({tag, "_data"}, fetch_data, 32'hA000_0000 | {9'b0, addr});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        flush      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;

        // Reset with the QSPI busy line toggling underneath.
        @(posedge clk);
        #1;
        check("rst_start", 32'(qspi_start), 32'd0);
        check("rst_valid", 32'(fetch_valid), 32'd0);
        check("rst_data", fetch_data, 32'd0);
        check("rst_miss", 32'(miss_count), 32'd0);
        check("rst_qaddr", 32'(qspi_addr), 32'd0);
        @(posedge clk);
        #1;
        check("rst2_start", 32'(qspi_start), 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            if (qspi_start) break;
        end
        check("first_start", 32'(qspi_start), 32'd1);
        check("first_qaddr", 32'(qspi_addr), 32'h80_0000);

        // Idle fill stops after DEPTH reads.
        repeat (80) @(posedge clk);
        #1;
        check("fill_reads", 32'(rd_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("fill_addr", 32'(rd_log[i]), 32'h80_0000 + 32'(i));
        end
        check("full_start", 32'(qspi_start), 32'd0);

        for (int i = 0; i < 4; i++) begin
            pop_now("seq", 23'(i));
        end
        fetch_req = 1'b0;
        check("seq_miss", 32'(miss_count), 32'd0);
        wait_log("resume_to", 5, 30);
        check("resume_addr", 32'(rd_log[4]), 32'h80_0004);
        repeat (80) @(posedge clk);
        #1;

        // Jump to 0x100 while the buffer holds 4..7.
        n          = rd_log.size();
        fetch_req  = 1'b1;
        fetch_addr = 23'h100;
        #1;
        check("jump_novalid", 32'(fetch_valid), 32'd0);
        @(posedge clk);
        #1;
        check("jump_miss", 32'(miss_count), 32'd1);
        wait_valid("jump_to", 40);
        check("jump_data", fetch_data, 32'hA000_0100);
        check("jump_miss_hold", 32'(miss_count), 32'd1);
        fetch_req = 1'b0;
        wait_log("jump_log_to", n + 4, 80);
        check("jump_r0", 32'(rd_log[n]), 32'h80_0100);
        check("jump_r1", 32'(rd_log[n + 1]), 32'h80_0101);
        check("jump_r2", 32'(rd_log[n + 2]), 32'h80_0102);
        repeat (20) @(posedge clk);
        #1;

        // Flush while the read of 0x104 is in flight.
        pop_now("pre_flush", 23'h100);
        fetch_req = 1'b0;
        wait_busy("flush_busy_to", 20);
        repeat (3) @(posedge clk);
        #1;
        flush      = 1'b1;
        fetch_addr = 23'h40;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n     = rd_log.size();
        wait_log("flush_log_to", n + 1, 40);
        check("flush_qaddr", 32'(rd_log[n]), 32'h80_0040);
        check("flush_miss", 32'(miss_count), 32'd1);
        wait_log("flush_fill_to", n + 4, 80);
        repeat (20) @(posedge clk);
        #1;

        // Flush beats a pop that would otherwise hit.
        fetch_req  = 1'b1;
        fetch_addr = 23'h40;
        flush      = 1'b1;
        #1;
        check("flush_prio", 32'(fetch_valid), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_valid("refill_to", 40);
        check("refill_data", fetch_data, 32'hA000_0040);
        check("refill_miss", 32'(miss_count), 32'd1);
        fetch_req = 1'b0;
        repeat (60) @(posedge clk);
        #1;

        // Pop on the same edge as a completion keeps three words queued.
        pop_now("pc0", 23'h40);
        fetch_req = 1'b0;
        wait_busy("pc_busy_to", 20);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (!qspi_busy) break;
        end
        check("pc_done", 32'(qspi_busy), 32'd0);
        pop_now("pc1", 23'h41);
        pop_now("pc2", 23'h42);
        pop_now("pc3", 23'h43);
        pop_now("pc4", 23'h44);
        fetch_addr = 23'h45;
        #1;
        check("pc_empty", 32'(fetch_valid), 32'd0);
        @(posedge clk);
        #1;

        // Nine streamed pops wrap both pointers.
        for (int i = 0; i < 9; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = 23'h45 + 23'(i);
            wait_valid("stream_to", 40);
            check("stream_data", fetch_data, 32'hA000_0045 + 32'(i));
            @(posedge clk);
            #1;
        end
        fetch_req = 1'b0;
        check("stream_miss", 32'(miss_count), 32'd1);

        // Miss counter saturation.
        fetch_req = 1'b1;
        for (int i = 0; i < 65533; i++) begin
            fetch_addr = i[0] ? 23'h300 : 23'h200;
            @(posedge clk);
            #1;
        end
        check("miss_fffe", 32'(miss_count), 32'h0000_FFFE);
        for (int i = 65533; i < 65537; i++) begin
            fetch_addr = i[0] ? 23'h300 : 23'h200;
            @(posedge clk);
            #1;
        end
        check("miss_sat", 32'(miss_count), 32'h0000_FFFF);

        // Address wrap at the top of the 23-bit space.
        fetch_addr = 23'h7F_FFFF;
        wait_valid("top_to", 60);
        check("top_data", fetch_data, 32'hA07F_FFFF);
        n = rd_log.size();
        @(posedge clk);
        #1;
        fetch_addr = 23'h0;
        wait_valid("wrap_to", 40);
        check("wrap_data", fetch_data, 32'hA000_0000);
        check("wrap_qaddr", 32'(rd_log[n]), 32'h80_0000);
        check("wrap_miss", 32'(miss_count), 32'h0000_FFFF);
        fetch_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_prefetch_buffer.md
Name: rom_prefetch_buffer

Overview:
- Instruction prefetch buffer between the CU fetch path (pc, irin) and the QSPI ROM controller.
- Holds up to DEPTH consecutive 32-bit ROM words starting at the CU's current pc.
- While the CU executes, it issues further QSPI reads so sequential fetches hit without a flash round trip.
- Discards everything on a jump/flush, or on any fetch address that is not the next buffered word.

Parameters:
- DEPTH, 4, number of buffered words; power of two, 2..16.
- STEP, 1, pc increment between consecutive ROM words.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- flush  input  1  discard buffer and any in-flight read (driven from the jmp pcoe)
- fetch_req  input  1  CU requests the word at fetch_addr
- fetch_addr  input  23  CU pc
- fetch_valid  output  1  fetch_data holds the word for fetch_addr this cycle
- fetch_data  output  32  ROM word (the CU uses bits [9:0] as ir and [25:10] as immediate)
- qspi_start  output  1  request a QSPI read
- qspi_addr  output  24  {1'b1, read address}, flash ROM space
- qspi_data  input  32  QSPI read data, valid in the cycle qspi_busy falls
- qspi_busy  input  1  QSPI transaction in progress
- miss_count  output  16  saturating count of fetch misses

Behaviour:
- Reset (rst_n low at a clk edge): count=0, head_addr=0, next_addr=0, FSM=IDLE, stale=0, miss_count=0, qspi_start=0, fetch_valid=0, fetch_data=0. Reset mid-transaction abandons it with no write. The QSPI module shares the same reset.
- Storage is a circular FIFO of DEPTH words, rd_ptr/wr_ptr wrap modulo DEPTH.
  - head_addr = address of the word at rd_ptr.
  - next_addr = address of the next word to request.
  - All address arithmetic is 23-bit, wrapping modulo 2^23.
- fetch_valid = fetch_req && count!=0 && fetch_addr==head_addr && !flush. This is combinational; fetch_data = fifo[rd_ptr].
- Pop: when fetch_req && fetch_valid, the word is consumed at the clock edge. rd_ptr++, head_addr += STEP, count--.
- Miss: fetch_req && !fetch_valid && !flush.
  - Takes effect next edge: count=0, rd_ptr=wr_ptr, head_addr=next_addr=fetch_addr.
  - Sets stale=1 if FSM is ISSUE or WAIT.
  - miss_count += 1, saturating at 0xFFFF.
  - Asserting fetch_req again for the same address while it is in flight (count still 0) does NOT count as a new miss, provided head_addr already equals fetch_addr and a fill is pending.
- Flush: same as a miss using head_addr=next_addr=fetch_addr, but does not increment miss_count. Flush has priority over pop and over a simultaneous miss.
- FSM:
  - IDLE: if count + inflight < DEPTH (inflight = 0 in IDLE) and no miss/flush this cycle -> ISSUE. qspi_addr is latched as {1'b1, next_addr} and next_addr += STEP.
  - ISSUE: qspi_start=1; qspi_addr held stable. When qspi_busy==1 is sampled -> WAIT, and qspi_start drops in the same edge.
  - WAIT: when qspi_busy==0 sampled -> IDLE. At that edge:
    - if stale==0, write qspi_data to fifo[wr_ptr], wr_ptr++, count++;
    - if stale==1, drop the data and clear stale.
- Miss/flush in IDLE: next_addr is reloaded. Any issue decided in that cycle is suppressed; the next IDLE cycle issues from the new address.
- Miss/flush in the same cycle as WAIT completion: the completion is discarded and no write occurs.
- Pop and completion in the same edge: both apply, count unchanged. count never exceeds DEPTH because issue requires count+1 <= DEPTH and pop only lowers count.
- Full (count==DEPTH): FSM stays in IDLE, qspi_start=0.
- Latency from a miss at cycle 0:
  - qspi_start rises at cycle 2 (cycle 1 IDLE issue decision).
  - The word is written at the edge where busy falls; fetch_valid rises the cycle after. There is no bypass path.
- qspi_start is never high in IDLE or WAIT, and at most one QSPI transaction is outstanding at a time.

Test Plan:
- Reset: hold rst_n=0 two cycles with qspi_busy toggling -> all outputs 0, qspi_start=0; release -> first qspi_start within 2 cycles with qspi_addr=24'h800000.
- Sequential fill, DEPTH=4, model QSPI busy for 10 cycles, returning data=0xA000_0000|addr:
  - with no fetch_req -> exactly 4 reads at addr 0..3, then qspi_start stays 0;
  - fetch_req at 0,1,2,3 -> fetch_valid each cycle with matching data, miss_count=0, reads resume at 4.
- Jump miss: buffer holding 0..3, fetch_addr=0x100 -> miss_count=1, no fetch_valid until the read of 0x100 completes, then data=0xA000_0100; the following reads are 0x101, 0x102, ...
- Flush mid-WAIT: flush asserted while reading addr 5 with fetch_addr=0x40 -> addr-5 data is not written, next qspi_addr=0x800040, miss_count unchanged.
- Simultaneous pop+completion with count=3 -> count stays 3, data order preserved; wrap test with 9 consecutive pops checks rd_ptr/wr_ptr wrap.
- Saturation/wrap:
  - force 65537 misses -> miss_count=0xFFFF;
  - fetch at 0x7FFFFF followed by a sequential read -> next qspi_addr=0x800000.
